contador_rom: RTL and testbench
===============================

CONTADOR_ROM -- requirements
Module: contador_rom

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 The block SHALL expose parameter NOTE_TICKS, default 12_500_000, meaning clock cycles per note (0.25 s at 50 MHz); legal range 2..16_777_216.
REQ-003 The block SHALL expose port clk, input, 1 bit: rising-edge system clock, 50 MHz nominal.
REQ-004 The block SHALL expose port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL expose port direccion_nota, output, 5 bits: current melody note address (0..31).
REQ-006 The block SHALL expose port count_time, output, 24 bits: cycles elapsed within the current note.
REQ-007 The block SHALL expose port frecuencia_de_nota, output, 16 bits: half-period count for the current note (0 = rest).

Function
REQ-008 The block SHALL consist of a registered note timer/address counter feeding a combinational 32-entry ROM.
REQ-009 count_time SHALL increment by 1 on every clk rising edge while rst is low and count_time < NOTE_TICKS-1.
REQ-010 When count_time equals NOTE_TICKS-1, the next edge SHALL load count_time with 0 and increment direccion_nota by 1.
REQ-011 direccion_nota SHALL wrap from 31 to 0; the melody SHALL loop indefinitely.
REQ-012 direccion_nota SHALL change only on a count_time terminal edge or reset; each address SHALL last exactly NOTE_TICKS cycles.
REQ-013 frecuencia_de_nota SHALL be a purely combinational function of direccion_nota, valid in the same cycle (zero latency).
REQ-014 ROM values SHALL equal floor(50e6/(2*f)) - 1, so a downstream toggle-at-count>=value divider produces tone f.
REQ-015 Note codes SHALL be: G4=63774, A4=56817, B4=50618, C5=47777, D5=42564, E5=37920, F5=35792, G5=31887, REST=0.
REQ-016 ROM contents by address SHALL be:
- 0..6: G4 G4 A4 G4 C5 B4 REST
- 7..13: G4 G4 A4 G4 D5 C5 REST
- 14..21: G4 G4 G5 E5 C5 B4 A4 REST
- 22..27: F5 F5 E5 C5 D5 C5
- 28..31: REST
REQ-017 Consumers SHALL treat frecuencia_de_nota = 0 as silence; the block itself SHALL take no special action on rests.
REQ-018 All arithmetic SHALL be unsigned; count_time SHALL never exceed NOTE_TICKS-1.

Reset
REQ-019 While rst is high at a clk edge, count_time SHALL load 0 and direccion_nota SHALL load 0, so frecuencia_de_nota = 63774.
REQ-020 Reset SHALL take priority over counting and wrap, including when asserted on the terminal-count cycle.
REQ-021 After rst deasserts, the first counting edge SHALL yield count_time = 1.
REQ-022 Power-up initial values SHALL also be 0 for both registers, for simulation and FPGA init.

Verification
REQ-023 Apply rst for 2 cycles, then release -> direccion_nota=0, count_time=0, frecuencia_de_nota=63774; next edge count_time=1.
REQ-024 With NOTE_TICKS=4, run 4 edges after reset -> count_time sequence 1,2,3,0; direccion_nota becomes 1 on the 4th edge; frecuencia_de_nota=63774.
REQ-025 With NOTE_TICKS=4, run 128 edges -> direccion_nota walks 0..31 and returns to 0. Each address has the REQ-016 value: addr 2=56817, 4=47777, 6=0, 11=42564, 16=31887, 22=35792, 31=0.
REQ-026 With NOTE_TICKS=4, assert rst when count_time=3 and direccion_nota=5 -> next edge both outputs 0, no increment to 6.
REQ-027 With NOTE_TICKS=4, assert rst mid-note at address 17 (count_time=1) for 1 cycle -> address 0 and count_time 0; a full 4-cycle note follows before address 1.
REQ-028 Default NOTE_TICKS, 12_500_000 edges after reset -> direccion_nota=1, count_time=0; no 24-bit overflow observed.

Source files
------------

// File: rtl/contador_rom.sv
`default_nettype none
// ============================================================================
//  Module      : contador_rom
//  Description : Melody sequencer. A registered note timer counts NOTE_TICKS
//                clock cycles per note and then advances a 5-bit note address.
//                The address drives a combinational 32-entry ROM, which returns
//                the half-period count of that note (0 means rest).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NOTE_TICKS         : clock cycles per note (legal range 2..16_777_216)
//  Ports
//    clk                : in  1  rising-edge system clock (50 MHz nominal)
//    rst                : in  1  synchronous active-high reset
//    direccion_nota     : out 5  current melody note address (0..31)
//    count_time         : out 24 cycles elapsed within the current note
//    frecuencia_de_nota : out 16 half-period count of the current note
// ============================================================================
module contador_rom #(
  parameter int unsigned NOTE_TICKS = 12_500_000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [4:0]  direccion_nota,
  output logic [23:0] count_time,
  output logic [15:0] frecuencia_de_nota
);

  // Last count value inside one note. NOTE_TICKS = 2^24 still fits in 24 bits
  // after the subtraction.
  localparam logic [23:0] c_LAST = 24'(NOTE_TICKS - 1);

  // Half-period counts: floor(50e6 / (2 * f)) - 1
  localparam logic [15:0] c_G4   = 16'd63774;
  localparam logic [15:0] c_A4   = 16'd56817;
  localparam logic [15:0] c_B4   = 16'd50618;
  localparam logic [15:0] c_C5   = 16'd47777;
  localparam logic [15:0] c_D5   = 16'd42564;
  localparam logic [15:0] c_E5   = 16'd37920;
  localparam logic [15:0] c_F5   = 16'd35792;
  localparam logic [15:0] c_G5   = 16'd31887;
  localparam logic [15:0] c_REST = 16'd0;

  // Declaration initialisers give the same zero state at power-up on FPGAs
  // as the reset does.
  logic [23:0] r_count = '0;
  logic [4:0]  r_addr  = '0;
  logic        w_terminal;
  logic [15:0] w_freq;

  // ">=" rather than "==" so that the counter can never run past the last
  // value even if it were somehow disturbed.
  assign w_terminal = (r_count >= c_LAST);

  // --------------------------------------------------------------------------
  // Note timer and address counter. The 5-bit address wraps 31 -> 0 by
  // natural overflow, so the melody loops forever.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_addr  <= '0;
    end else if (w_terminal) begin
      r_count <= '0;
      r_addr  <= r_addr + 5'd1;
    end else begin
      r_count <= r_count + 24'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Melody ROM, purely combinational: the note value follows the address in
  // the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_freq = c_REST;
    case (r_addr)
      5'd0:    w_freq = c_G4;
      5'd1:    w_freq = c_G4;
      5'd2:    w_freq = c_A4;
      5'd3:    w_freq = c_G4;
      5'd4:    w_freq = c_C5;
      5'd5:    w_freq = c_B4;
      5'd6:    w_freq = c_REST;
      5'd7:    w_freq = c_G4;
      5'd8:    w_freq = c_G4;
      5'd9:    w_freq = c_A4;
      5'd10:   w_freq = c_G4;
      5'd11:   w_freq = c_D5;
      5'd12:   w_freq = c_C5;
      5'd13:   w_freq = c_REST;
      5'd14:   w_freq = c_G4;
      5'd15:   w_freq = c_G4;
      5'd16:   w_freq = c_G5;
      5'd17:   w_freq = c_E5;
      5'd18:   w_freq = c_C5;
      5'd19:   w_freq = c_B4;
      5'd20:   w_freq = c_A4;
      5'd21:   w_freq = c_REST;
      5'd22:   w_freq = c_F5;
      5'd23:   w_freq = c_F5;
      5'd24:   w_freq = c_E5;
      5'd25:   w_freq = c_C5;
      5'd26:   w_freq = c_D5;
      5'd27:   w_freq = c_C5;
      default: w_freq = c_REST;   // 28..31: trailing rests
    endcase
  end

  assign direccion_nota     = r_addr;
  assign count_time         = r_count;
  assign frecuencia_de_nota = w_freq;

endmodule
`default_nettype wire

// File: tb/tb_contador_rom.sv
`default_nettype none
// ============================================================================
//  Module      : tb_contador_rom
//  Description : Self-checking bench for contador_rom with NOTE_TICKS = 4.
//                Table-driven reset/first-note vectors, a full melody walk
//                against a hand-written ROM table, and reset corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_contador_rom;

  logic        clk;
  logic        rst;
  logic [4:0]  direccion_nota;
  logic [23:0] count_time;
  logic [15:0] frecuencia_de_nota;

  int n_pass  = 0;
  int n_total = 0;

  contador_rom #(.NOTE_TICKS(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .direccion_nota     (direccion_nota),
    .count_time         (count_time),
    .frecuencia_de_nota (frecuencia_de_nota)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic [4:0]  addr;
    logic [23:0] cnt;
    logic [15:0] freq;
  } vec_t;

  vec_t            vecs [12];
  logic [15:0]     rom_exp [32];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int a, input int c);
    check({tag, " addr"}, int'(direccion_nota), a);
    check({tag, " cnt"},  int'(count_time), c);
    check({tag, " freq"}, int'(frecuencia_de_nota), int'(rom_exp[a[4:0]]));
  endtask

  // Advance until the given address/count is reached (bounded).
  task automatic run_to(input int a, input int c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (int'(direccion_nota) == a && int'(count_time) == c) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      n_total++;
      $display("FAIL run_to: got addr=%0d cnt=%0d, expected addr=%0d cnt=%0d within 200 cycles",
               direccion_nota, count_time, a, c);
    end
  endtask

  initial begin
    bit ok;
    int m_addr, m_cnt;

    rom_exp = '{63774, 63774, 56817, 63774, 47777, 50618, 0,
                63774, 63774, 56817, 63774, 42564, 47777, 0,
                63774, 63774, 31887, 37920, 47777, 50618, 56817, 0,
                35792, 35792, 37920, 47777, 42564, 47777,
                0, 0, 0, 0};

    //          rst   addr  cnt   freq
    vecs[0]  = '{1'b1, 5'd0, 24'd0, 16'd63774};
    vecs[1]  = '{1'b1, 5'd0, 24'd0, 16'd63774};
    vecs[2]  = '{1'b0, 5'd0, 24'd1, 16'd63774};
    vecs[3]  = '{1'b0, 5'd0, 24'd2, 16'd63774};
    vecs[4]  = '{1'b0, 5'd0, 24'd3, 16'd63774};
    vecs[5]  = '{1'b0, 5'd1, 24'd0, 16'd63774};
    vecs[6]  = '{1'b0, 5'd1, 24'd1, 16'd63774};
    vecs[7]  = '{1'b0, 5'd1, 24'd2, 16'd63774};
    vecs[8]  = '{1'b0, 5'd1, 24'd3, 16'd63774};
    vecs[9]  = '{1'b0, 5'd2, 24'd0, 16'd56817};
    vecs[10] = '{1'b1, 5'd0, 24'd0, 16'd63774};
    vecs[11] = '{1'b0, 5'd0, 24'd1, 16'd63774};

    rst = 1'b1;
    #1;
    check("powerup addr", int'(direccion_nota), 0);
    check("powerup cnt",  int'(count_time), 0);
    check("powerup freq", int'(frecuencia_de_nota), 63774);

    // Table-driven reset and first-note vectors
    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst;
      step();
      check($sformatf("vec%0d addr", i), int'(direccion_nota),     int'(vecs[i].addr));
      check($sformatf("vec%0d cnt",  i), int'(count_time),         int'(vecs[i].cnt));
      check($sformatf("vec%0d freq", i), int'(frecuencia_de_nota), int'(vecs[i].freq));
    end

    // Full melody walk: 128 edges return to the same position.
    m_addr = 0;
    m_cnt  = 1;
    for (int i = 0; i < 128; i++) begin
      step();
      if (m_cnt == 3) begin
        m_cnt  = 0;
        m_addr = (m_addr + 1) % 32;
      end else begin
        m_cnt++;
      end
      check($sformatf("walk%0d", i), int'(direccion_nota) * 8 + int'(count_time),
            m_addr * 8 + m_cnt);
      check($sformatf("walk%0d freq", i), int'(frecuencia_de_nota), int'(rom_exp[m_addr]));
    end
    check("wrap addr", int'(direccion_nota), 0);
    check("wrap cnt",  int'(count_time), 1);

    // Reset on the terminal-count cycle of address 5: no advance to 6.
    run_to(5, 3, ok);
    if (ok) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_all("rst@term", 0, 0);
    end

    // One-cycle reset mid-note at address 17, then a full note at address 0.
    run_to(17, 1, ok);
    if (ok) begin
      check("at17 freq", int'(frecuencia_de_nota), 37920);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_all("rst@17", 0, 0);
      for (int k = 1; k <= 3; k++) begin
        step();
        check_all($sformatf("post%0d", k), 0, k);
      end
      step();
      check_all("post4", 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
